// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard for in-order issue: tracks pending writes
// with fixed-latency countdown or variable-latency writeback completion.
module hazard_scoreboard #(
    parameter int NREG = 32,
    parameter int REGW = 5,
    parameter int LATW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [REGW-1:0] rs1,
    input  logic [REGW-1:0] rs2,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic [REGW-1:0] rd,
    input  logic            rd_we,
    input  logic [LATW-1:0] lat,
    input  logic            flush,
    input  logic            wb_valid,
    input  logic [REGW-1:0] wb_rd,
    output logic            stall,
    output logic            issue_ack,
    output logic [NREG-1:0] busy_vec,
    output logic [REGW:0]   inflight
);

    localparam int NPAD = 1 << REGW;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busyNxt;
    logic [NREG-1:0] varFlag;
    logic [NREG-1:0] varNxt;
    logic [LATW-1:0] cnt    [NREG];
    logic [LATW-1:0] cntNxt [NREG];
    logic [NPAD-1:0] busyPad;
    logic [NPAD-1:0] varPad;
    logic [LATW-1:0] cntRd;
    logic            rawHit;
    logic            wawHit;
    logic            alloc;
    logic [REGW:0]   popNxt;

    always_comb begin
        busyPad = '0;
        varPad  = '0;
        busyPad[NREG-1:0] = busy;
        varPad[NREG-1:0]  = varFlag;
        cntRd = '0;
        for (int r = 0; r < NREG; r++) begin
            if (rd == REGW'(r)) cntRd = cnt[r];
        end
        rawHit = (rs1_used && rs1 != '0 && busyPad[rs1])
              || (rs2_used && rs2 != '0 && busyPad[rs2]);
        // A younger write must not finish before an older one to rd
        wawHit = rd_we && rd != '0 && busyPad[rd]
              && (varPad[rd] || cntRd > lat || lat == '0);
        stall     = issue_valid && !flush && (rawHit || wawHit);
        issue_ack = issue_valid && !flush && !stall;
        alloc     = issue_ack && rd_we && rd != '0;
    end

    always_comb begin
        popNxt = '0;
        for (int r = 0; r < NREG; r++) begin
            busyNxt[r] = busy[r];
            varNxt[r]  = varFlag[r];
            cntNxt[r]  = cnt[r];
            if (busy[r] && !varFlag[r]) begin
                cntNxt[r] = cnt[r] - LATW'(1);
                // Result becomes forwardable once the count steps down to 1
                if ({1'b0, cnt[r]} <= (LATW+1)'(2)) busyNxt[r] = 1'b0;
            end
            if (wb_valid && wb_rd == REGW'(r) && varFlag[r]) begin
                busyNxt[r] = 1'b0;
                varNxt[r]  = 1'b0;
            end
            if (alloc && rd == REGW'(r)) begin
                busyNxt[r] = 1'b1;
                varNxt[r]  = (lat == '0);
                cntNxt[r]  = lat;
            end
        end
        busyNxt[0] = 1'b0;
        varNxt[0]  = 1'b0;
        cntNxt[0]  = '0;
        for (int r = 0; r < NREG; r++) begin
            popNxt = popNxt + (REGW+1)'(busyNxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            varFlag  <= '0;
            inflight <= '0;
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            busy     <= busyNxt;
            varFlag  <= varNxt;
            inflight <= popNxt;
            for (int r = 0; r < NREG; r++) cnt[r] <= cntNxt[r];
        end
    end

    assign busy_vec = busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized checks of hazard_scoreboard against a
// cycle-stamped behavioural model of pending register writes.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic [4:0]  rd;
    logic        rd_we;
    logic [2:0]  lat;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall;
    logic        issue_ack;
    logic [31:0] busy_vec;
    logic [5:0]  inflight;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: a fixed-latency write issued at cycle t with latency L keeps
    // the register busy until cycle t+max(L,2); variable ones until wb.
    logic mVar [32];
    int   freeAt [32];
    int   issCyc [32];
    int   issLat [32];

    hazard_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .rs1        (rs1),
        .rs2        (rs2),
        .rs1_used   (rs1_used),
        .rs2_used   (rs2_used),
        .rd         (rd),
        .rd_we      (rd_we),
        .lat        (lat),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .stall      (stall),
        .issue_ack  (issue_ack),
        .busy_vec   (busy_vec),
        .inflight   (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic mBusy(int r);
        return r != 0 && (mVar[r] || cyc < freeAt[r]);
    endfunction

    function automatic int mCnt(int r);
        return issLat[r] - (cyc - issCyc[r] - 1);
    endfunction

    function automatic logic [31:0] mVec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = mBusy(r);
        return v;
    endfunction

    function automatic int mPop();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(mBusy(r));
        return n;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 32; r++) begin
            mVar[r] = 1'b0;
            freeAt[r] = 0;
            issCyc[r] = 0;
            issLat[r] = 0;
        end
    endtask

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input int r1, input logic u1,
                         input int r2, input logic u2, input int d,
                         input logic we, input int l, input logic fl,
                         input logic wv, input int wr);
        issue_valid = iv;
        rs1 = 5'(r1);
        rs1_used = u1;
        rs2 = 5'(r2);
        rs2_used = u2;
        rd = 5'(d);
        rd_we = we;
        lat = 3'(l);
        flush = fl;
        wb_valid = wv;
        wb_rd = 5'(wr);
        #1;
    endtask

    task automatic tick();
        logic raw, waw, eStall, eAck;
        int d;
        #1;
        d = int'(rd);
        eStall = 1'b0;
        if (rst_n) begin
            raw = (rs1_used && mBusy(int'(rs1)))
               || (rs2_used && mBusy(int'(rs2)));
            waw = rd_we && mBusy(d)
               && (mVar[d] || mCnt(d) > int'(lat) || lat == 0);
            eStall = issue_valid && !flush && (raw || waw);
        end
        eAck = issue_valid && !flush && !eStall;
        check("stall", stall, eStall);
        check("issue_ack", issue_ack, eAck);
        if (rst_n) begin
            if (wb_valid && wb_rd != 0 && mVar[int'(wb_rd)])
                mVar[int'(wb_rd)] = 1'b0;
            if (eAck && rd_we && d != 0) begin
                if (lat == 0) begin
                    mVar[d] = 1'b1;
                    freeAt[d] = 0;
                end else begin
                    mVar[d] = 1'b0;
                    issCyc[d] = cyc;
                    issLat[d] = int'(lat);
                    freeAt[d] = cyc + ((lat < 2) ? 2 : int'(lat));
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        check("busy_vec", busy_vec, mVec());
        check("inflight", inflight, mPop());
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    initial begin
        modelReset();
        rst_n = 1'b0;
        drive(1, 3, 1, 4, 1, 6, 1, 2, 0, 0, 0);
        check("rst_busy", busy_vec, 0);
        check("rst_inflight", inflight, 0);
        check("rst_stall", stall, 0);
        check("rst_ack", issue_ack, 1);
        tick();
        check("rst_hold_busy", busy_vec, 0);
        rst_n = 1'b1;
        idle(2);

        // rd=5 lat=3, dependent read stalls two cycles
        drive(1, 0, 0, 0, 0, 5, 1, 3, 0, 0, 0);
        check("r37_issue", issue_ack, 1);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("r37_stall1", stall, 1);
        tick();
        check("r37_stall2", stall, 1);
        tick();
        check("r37_ack3", issue_ack, 1);
        tick();
        idle(2);

        // variable latency rd=7 released by writeback
        drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check("r38_stall", stall, 1);
            tick();
        end
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 1, 7);
        check("r38_nobypass", stall, 1);
        tick();
        check("r38_cleared", busy_vec[7], 0);
        drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        check("r38_dep_ack", issue_ack, 1);
        tick();
        idle(1);

        // WAW ordering on rd=3
        drive(1, 0, 0, 0, 0, 3, 1, 4, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        check("r39_waw_stall", stall, 1);
        drive(1, 0, 0, 0, 0, 3, 1, 5, 0, 0, 0);
        check("r39_waw_ack", issue_ack, 1);
        tick();
        drive(1, 0, 0, 0, 0, 3, 1, 4, 0, 0, 0);
        check("r39_cnt5_stall", stall, 1);
        drive(1, 0, 0, 0, 0, 3, 1, 5, 0, 0, 0);
        check("r39_cnt5_ack", issue_ack, 1);
        tick();
        idle(7);

        // x0 is never tracked
        drive(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        check("r40_ack", issue_ack, 1);
        tick();
        check("r40_busy", busy_vec, 0);
        drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        check("r40_rs0", stall, 0);
        tick();

        // flush dominates a pending hazard
        drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        tick();
        drive(1, 9, 1, 0, 0, 10, 1, 2, 1, 0, 0);
        check("r41_stall", stall, 0);
        check("r41_ack", issue_ack, 0);
        tick();
        check("r41_noalloc", busy_vec[10], 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
        tick();

        // asynchronous reset between edges
        for (int r = 11; r <= 13; r++) begin
            drive(1, 0, 0, 0, 0, r, 1, 0, 0, 0, 0);
            tick();
        end
        check("r42_inflight3", inflight, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("r42_busy_now", busy_vec, 0);
        check("r42_infl_now", inflight, 0);
        modelReset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11);
        tick();
        check("r36_wb_ignored", busy_vec, 0);
        idle(1);

        // randomized traffic over a small register window
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 7,
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 7));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
